calc_cmd_scheduler: RTL and testbench

Command scheduler in front of `calc_top`. It arbitrates keypad-style commands from two sources, keypad and script/UART, and queues them in a small FIFO. It then replays each command on the calculator's `cmd` port, holding it for a fixed number of cycles and following it with an idle gap, and only issues when the calculator reports ready. It also handles calculator error recovery by flushing the queue and issuing a clear command on request.

---
 rtl/calc_cmd_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_calc_cmd_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_scheduler.sv
// Command scheduler in front of calc_top: round-robin arbitration of two
// command sources into a small FIFO, paced replay on calc_cmd, and error recovery.
module calc_cmd_scheduler #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 10,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter logic [3:0]  IDLE_CMD    = 4'b1111,
  parameter logic [3:0]  CLEAR_CMD   = 4'b1011
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         src0_valid,
  input  logic [3:0]                   src0_cmd,
  output logic                         src0_ready,
  input  logic                         src1_valid,
  input  logic [3:0]                   src1_cmd,
  output logic                         src1_ready,
  input  logic [1:0]                   calc_status,
  input  logic                         err_clear,
  output logic [3:0]                   calc_cmd,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         err_flag
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam logic [1:0]  STAT_READY = 2'b00;
  localparam logic [1:0]  STAT_ERROR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP,
    S_ERROR,
    S_CLEAR
  } state_e;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [3:0]         cmd_lat_q, cmd_lat_d;
  logic [3:0]         calc_cmd_q, calc_cmd_d;
  logic               err_flag_q, err_flag_d;
  logic               last_grant_q, last_grant_d;
  logic [3:0]         mem_q [DEPTH];
  logic [3:0]         mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               can_push;
  logic               grant0;
  logic               grant1;
  logic               push;
  logic               pop;
  logic               flush;
  logic [3:0]         push_cmd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Arbitration, FIFO bookkeeping, sequencing FSM and registered output decode.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    cmd_lat_d    = cmd_lat_q;
    last_grant_d = last_grant_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pop          = 1'b0;
    flush        = 1'b0;

    can_push   = (count_q < CNT_W'(DEPTH)) && (state_q != S_ERROR) &&
                 (state_q != S_CLEAR) && reset;
    // last_grant_q==1 means src1 won last, so src0 has priority on a conflict
    grant0     = src0_valid && (!src1_valid || last_grant_q);
    grant1     = src1_valid && (!src0_valid || !last_grant_q);
    src0_ready = grant0 && can_push;
    src1_ready = grant1 && can_push;
    push       = src0_ready || src1_ready;
    push_cmd   = src0_ready ? src0_cmd : src1_cmd;
    if (push) begin
      last_grant_d = src1_ready;
    end

    case (state_q)
      S_IDLE: begin
        if (calc_status == STAT_ERROR) begin
          state_d = S_ERROR;
        end else if ((count_q != '0) && (calc_status == STAT_READY)) begin
          pop        = 1'b1;
          cmd_lat_d  = mem_q[rd_ptr_q];
          hold_cnt_d = HOLD_W'(HOLD_CYCLES - 1);
          state_d    = S_DRIVE;
        end
      end
      S_DRIVE, S_CLEAR: begin
        if (hold_cnt_q == '0) begin
          gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
          state_d   = S_GAP;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      S_GAP: begin
        if (calc_status == STAT_ERROR) begin
          state_d = S_ERROR;
        end else if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      S_ERROR: begin
        flush = 1'b1;
        if (err_clear) begin
          hold_cnt_d = HOLD_W'(HOLD_CYCLES - 1);
          state_d    = S_CLEAR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_cmd;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    case (state_d)
      S_DRIVE: calc_cmd_d = cmd_lat_d;
      S_CLEAR: calc_cmd_d = CLEAR_CMD;
      default: calc_cmd_d = IDLE_CMD;
    endcase
    err_flag_d = (state_d == S_ERROR) || (state_d == S_CLEAR);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      hold_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      cmd_lat_q    <= '0;
      calc_cmd_q   <= IDLE_CMD;
      err_flag_q   <= 1'b0;
      last_grant_q <= 1'b1;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      cmd_lat_q    <= cmd_lat_d;
      calc_cmd_q   <= calc_cmd_d;
      err_flag_q   <= err_flag_d;
      last_grant_q <= last_grant_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign calc_cmd   = calc_cmd_q;
  assign fifo_count = count_q;
  assign err_flag   = err_flag_q;

endmodule

// File: tb/tb_calc_cmd_scheduler.sv
// Bench for calc_cmd_scheduler: arbitration vector table, scoreboarded replay
// order/hold length, and hand sequences for stall, error recovery and reset.
module tb_calc_cmd_scheduler;

  localparam logic [3:0] IDLE = 4'b1111;
  localparam logic [3:0] CLR  = 4'b1011;
  localparam int         HOLD = 10;
  localparam int         PERIOD = 13;

  logic       clock = 1'b0;
  logic       reset;
  logic       src0_valid, src1_valid;
  logic [3:0] src0_cmd, src1_cmd;
  logic       src0_ready, src1_ready;
  logic [1:0] calc_status;
  logic       err_clear;
  logic [3:0] calc_cmd;
  logic [2:0] fifo_count;
  logic       err_flag;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [3:0] exp_q[$];
  int         start_q[$];
  logic [3:0] mon_prev;
  int         mon_run;

  typedef struct {
    logic       v0;
    logic [3:0] c0;
    logic       v1;
    logic [3:0] c1;
    logic       r0;
    logic       r1;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl[6];

  calc_cmd_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .src0_valid  (src0_valid),
    .src0_cmd    (src0_cmd),
    .src0_ready  (src0_ready),
    .src1_valid  (src1_valid),
    .src1_cmd    (src1_cmd),
    .src1_ready  (src1_ready),
    .calc_status (calc_status),
    .err_clear   (err_clear),
    .calc_cmd    (calc_cmd),
    .fifo_count  (fifo_count),
    .err_flag    (err_flag)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Replay monitor: every new non-clear command is popped from the scoreboard.
  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      mon_prev = IDLE;
      mon_run  = 0;
    end else begin
      if (calc_cmd !== mon_prev) begin
        if (mon_prev != IDLE) check("hold_len", mon_run, HOLD);
        if (calc_cmd != IDLE && !err_flag) begin
          start_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_cmd: got %0h, expected none (cycle %0d)", calc_cmd, cyc);
          end else begin
            check("order", int'(calc_cmd), int'(exp_q.pop_front()));
          end
        end
        mon_run = 1;
      end else begin
        mon_run++;
      end
      mon_prev = calc_cmd;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 4'h3, 1'b1, 4'h4, 1'b1, 1'b0, 3'd1};
    tbl[1] = '{1'b1, 4'h5, 1'b1, 4'h6, 1'b0, 1'b1, 3'd2};
    tbl[2] = '{1'b1, 4'h7, 1'b0, 4'h0, 1'b1, 1'b0, 3'd3};
    tbl[3] = '{1'b1, 4'h8, 1'b1, 4'h9, 1'b0, 1'b1, 3'd4};
    tbl[4] = '{1'b1, 4'hA, 1'b1, 4'hC, 1'b0, 1'b0, 3'd4};
    tbl[5] = '{1'b0, 4'h0, 1'b1, 4'hD, 1'b0, 1'b0, 3'd4};

    // Reset: readies held low even with both sources valid.
    reset = 1'b0; src0_valid = 1'b1; src1_valid = 1'b1;
    src0_cmd = 4'h1; src1_cmd = 4'h2; calc_status = 2'b00; err_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_cmd", calc_cmd, IDLE);
    check("rst_count", fifo_count, 0);
    check("rst_err", err_flag, 0);
    check("rst_rdy0", src0_ready, 0);
    check("rst_rdy1", src1_ready, 0);
    @(negedge clock);
    src0_valid = 1'b0; src1_valid = 1'b0; calc_status = 2'b01;
    reset = 1'b1;

    // err_clear outside ERROR is ignored.
    @(negedge clock);
    err_clear = 1'b1;
    @(posedge clock); #1;
    err_clear = 1'b0;
    check("ign_clr_err", err_flag, 0);
    check("ign_clr_cmd", calc_cmd, IDLE);

    // Arbitration table while the calculator is busy (no pops).
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      src0_valid = tbl[i].v0; src0_cmd = tbl[i].c0;
      src1_valid = tbl[i].v1; src1_cmd = tbl[i].c1;
      #1;
      check("arb_rdy0", src0_ready, tbl[i].r0);
      check("arb_rdy1", src1_ready, tbl[i].r1);
      if (tbl[i].r0) exp_q.push_back(tbl[i].c0);
      else if (tbl[i].r1) exp_q.push_back(tbl[i].c1);
      @(posedge clock); #1;
      check("arb_count", fifo_count, tbl[i].cnt);
    end
    src0_valid = 1'b0; src1_valid = 1'b0;

    // Busy / not-ready stall for 30 cycles.
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      calc_status = (i < 15) ? 2'b01 : 2'b11;
      @(posedge clock); #1;
      check("stall_cmd", calc_cmd, IDLE);
    end
    check("stall_count", fifo_count, 4);
    @(negedge clock);
    calc_status = 2'b00;
    @(posedge clock); #1;
    check("resume_cmd", calc_cmd, 4'h3);
    check("resume_count", fifo_count, 3);

    // Error during GAP with three entries queued.
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (calc_cmd != 4'h3) break;
    end
    check("gap_entry", calc_cmd, IDLE);
    @(negedge clock);
    calc_status = 2'b10;
    exp_q.delete();
    @(posedge clock); #1;
    check("err_flag_set", err_flag, 1);
    check("err_count_hold", fifo_count, 3);
    @(posedge clock); #1;
    check("err_count_flush", fifo_count, 0);
    check("err_cmd", calc_cmd, IDLE);
    @(negedge clock);
    src0_valid = 1'b1; src1_valid = 1'b1; #1;
    check("err_rdy0", src0_ready, 0);
    check("err_rdy1", src1_ready, 0);
    @(negedge clock);
    src0_valid = 1'b0; src1_valid = 1'b0;
    err_clear = 1'b1; calc_status = 2'b00;
    @(posedge clock); #1;
    check("clr_cmd", calc_cmd, CLR);
    check("clr_err", err_flag, 1);
    @(negedge clock);
    err_clear = 1'b0;
    for (int i = 1; i < HOLD; i++) begin
      @(posedge clock); #1;
      check("clr_hold", calc_cmd, CLR);
    end
    @(posedge clock); #1;
    check("clr_done_cmd", calc_cmd, IDLE);
    check("clr_done_err", err_flag, 0);
    repeat (4) @(posedge clock);

    // Single command: visible two cycles after the push, held for 10 cycles.
    @(negedge clock);
    src0_valid = 1'b1; src0_cmd = 4'h1; #1;
    check("single_rdy", src0_ready, 1);
    exp_q.push_back(4'h1);
    @(posedge clock); #1;
    src0_valid = 1'b0;
    check("single_count1", fifo_count, 1);
    check("single_cmd_pre", calc_cmd, IDLE);
    for (int i = 0; i <= HOLD; i++) begin
      @(posedge clock); #1;
      check("single_cmd", calc_cmd, (i < HOLD) ? 4'h1 : IDLE);
      if (i == 0) check("single_count0", fifo_count, 0);
    end
    repeat (4) @(posedge clock);

    // Back-to-back sequence queued while busy, then replayed with fixed spacing.
    @(negedge clock);
    calc_status = 2'b01;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] seq_cmds [4];
      seq_cmds = '{4'h1, 4'hA, 4'h2, 4'hE};
      @(negedge clock);
      src0_valid = 1'b1; src0_cmd = seq_cmds[i]; #1;
      check("seq_rdy", src0_ready, 1);
      exp_q.push_back(seq_cmds[i]);
      @(posedge clock); #1;
      check("seq_count", fifo_count, i + 1);
    end
    src0_valid = 1'b0;
    start_q.delete();
    @(negedge clock);
    calc_status = 2'b00;
    for (int i = 0; i < 80 && start_q.size() < 4; i++) @(posedge clock);
    check("seq_starts", start_q.size(), 4);
    for (int k = 1; k < start_q.size(); k++)
      check("seq_period", start_q[k] - start_q[k-1], PERIOD);
    repeat (14) @(posedge clock);
    check("seq_drained", exp_q.size(), 0);

    // Reset asserted in cycle 5 of DRIVE takes effect without a clock edge.
    @(negedge clock);
    src1_valid = 1'b1; src1_cmd = 4'h5; #1;
    check("rd_rdy1", src1_ready, 1);
    exp_q.push_back(4'h5);
    @(posedge clock); #1;
    src1_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (calc_cmd == 4'h5) break;
    end
    check("rd_drive", calc_cmd, 4'h5);
    @(negedge clock);
    src0_valid = 1'b1; src0_cmd = 4'h2; #1;
    check("rd_rdy0", src0_ready, 1);
    exp_q.push_back(4'h2);
    @(posedge clock); #1;
    src0_valid = 1'b0;
    check("rd_count", fifo_count, 1);
    repeat (3) @(posedge clock);
    #3;
    src0_valid = 1'b1; src1_valid = 1'b1;
    reset = 1'b0;
    #1;
    check("rd_cmd", calc_cmd, IDLE);
    check("rd_count0", fifo_count, 0);
    check("rd_rdy0_low", src0_ready, 0);
    check("rd_rdy1_low", src1_ready, 0);
    exp_q.delete();
    @(negedge clock);
    src0_valid = 1'b0; src1_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(posedge clock); #1;
    check("post_rst_cmd", calc_cmd, IDLE);
    check("post_rst_count", fifo_count, 0);
    check("final_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
